// File: rtl/cpu_onchip_memory_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slaves, selectable read latency,
// deterministic same-address write arbitration and an optional zero-fill after reset.
module cpu_onchip_memory_dp #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 32768,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  reset_req,
    input  logic                  clken,

    input  logic [ADDR_W-1:0]     s1_address,
    input  logic                  s1_chipselect,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0]     s1_writedata,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,
    output logic                  s1_waitrequest,

    input  logic [ADDR_W-1:0]     s2_address,
    input  logic                  s2_chipselect,
    input  logic                  s2_read,
    input  logic                  s2_write,
    input  logic [DATA_W/8-1:0]   s2_byteenable,
    input  logic [DATA_W-1:0]     s2_writedata,
    output logic [DATA_W-1:0]     s2_readdata,
    output logic                  s2_readdatavalid,
    output logic                  s2_waitrequest,

    output logic                  init_done,
    output logic [15:0]           collision_cnt,
    output logic                  fsm_state
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   clr_addr;
    logic [ADDR_W-1:0]   clr_addr_next;
    logic                clr_we;
    logic                en;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign en        = clken & ~reset_req;
    assign fsm_state = (state == ST_RUN);

    // Handshake: a request is accepted on a rising edge where chipselect and
    // read or write are high and waitrequest is low; the master must hold the
    // request stable while waitrequest is high. A read is answered by exactly
    // one readdatavalid pulse, which only appears in an enabled cycle.
    assign s1_waitrequest = ~init_done | ~en;
    assign s2_waitrequest = ~init_done | ~en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_addr  <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_next;
            clr_addr  <= clr_addr_next;
            init_done <= (state_next == ST_RUN);
        end
    end

    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        clr_we        = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (en) begin
                    clr_we        = 1'b1;
                    clr_addr_next = clr_addr + 1'b1;
                    if (clr_addr == ADDR_W'(DEPTH - 1)) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    logic s1_acc, s2_acc;
    logic s1_wr_acc, s2_wr_acc;
    logic s1_rd_acc, s2_rd_acc;
    logic collide;

    assign s1_acc    = s1_chipselect & (s1_read | s1_write) & ~s1_waitrequest;
    assign s2_acc    = s2_chipselect & (s2_read | s2_write) & ~s2_waitrequest;
    assign s1_wr_acc = s1_acc & s1_write;
    assign s2_wr_acc = s2_acc & s2_write;
    assign s1_rd_acc = s1_acc & s1_read & ~s1_write;
    assign s2_rd_acc = s2_acc & s2_read & ~s2_write;
    assign collide   = s1_wr_acc & s2_wr_acc & (s1_address == s2_address);

    // The clear engine borrows port 1's write path; the slaves are held off meanwhile.
    logic                p1_we;
    logic [ADDR_W-1:0]   p1_addr;
    logic [DATA_W-1:0]   p1_data;
    logic [BE_W-1:0]     p1_be;
    logic [DATA_W-1:0]   p1_word;
    logic                p2_we;
    logic [DATA_W-1:0]   p2_word;

    assign p1_we   = clr_we | s1_wr_acc;
    assign p1_addr = clr_we ? clr_addr : s1_address;
    assign p1_data = clr_we ? '0 : s1_writedata;
    assign p1_be   = clr_we ? '1 : s1_byteenable;
    assign p2_we   = s2_wr_acc & ~collide;

    always_comb begin
        p1_word = mem[p1_addr];
        p2_word = mem[s2_address];
        for (int b = 0; b < BE_W; b++) begin
            if (p1_be[b]) begin
                p1_word[b*8 +: 8] = p1_data[b*8 +: 8];
            end
            if (s2_byteenable[b]) begin
                p2_word[b*8 +: 8] = s2_writedata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (p1_we) begin
            mem[p1_addr] <= p1_word;
        end
        if (p2_we) begin
            mem[s2_address] <= p2_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            collision_cnt <= '0;
        end else if (collide && (collision_cnt != 16'hFFFF)) begin
            collision_cnt <= collision_cnt + 16'd1;
        end
    end

    // Read pipelines: data stages only load alongside a valid so readdata holds
    // its last value between pulses; the whole pipe freezes while en is low.
    logic [READ_LATENCY-1:0]             s1_pv, s2_pv;
    logic [READ_LATENCY-1:0][DATA_W-1:0] s1_pd, s2_pd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_pv <= '0;
            s2_pv <= '0;
            s1_pd <= '0;
            s2_pd <= '0;
        end else if (en) begin
            s1_pv[0] <= s1_rd_acc;
            s2_pv[0] <= s2_rd_acc;
            if (s1_rd_acc) begin
                s1_pd[0] <= mem[s1_address];
            end
            if (s2_rd_acc) begin
                s2_pd[0] <= mem[s2_address];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                s1_pv[i] <= s1_pv[i-1];
                s2_pv[i] <= s2_pv[i-1];
                if (s1_pv[i-1]) begin
                    s1_pd[i] <= s1_pd[i-1];
                end
                if (s2_pv[i-1]) begin
                    s2_pd[i] <= s2_pd[i-1];
                end
            end
        end
    end

    assign s1_readdata      = s1_pd[READ_LATENCY-1];
    assign s2_readdata      = s2_pd[READ_LATENCY-1];
    assign s1_readdatavalid = s1_pv[READ_LATENCY-1] & en;
    assign s2_readdatavalid = s2_pv[READ_LATENCY-1] & en;

endmodule

// File: tb/tb_cpu_onchip_memory_dp.sv
// Bench for cpu_onchip_memory_dp: two instances (read latency 1 and 2) share all
// inputs; read results are tracked in an expected queue tagged with the enabled cycle.
module tb_cpu_onchip_memory_dp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, reset_req, clken;
    logic        s1_cs, s1_rd, s1_wr, s2_cs, s2_rd, s2_wr;
    logic [3:0]  s1_be, s2_be, s1_a, s2_a;
    logic [31:0] s1_d, s2_d;

    // stream k: 0 = lat1/s1, 1 = lat1/s2, 2 = lat2/s1, 3 = lat2/s2
    logic [3:0]        rdv, wrq;
    logic [3:0][31:0]  rdd;
    logic [1:0]        idone, fsm;
    logic [1:0][15:0]  ccnt;

    cpu_onchip_memory_dp #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_l1 (
        .clk(clk), .reset_n(reset_n), .reset_req(reset_req), .clken(clken),
        .s1_address(s1_a), .s1_chipselect(s1_cs), .s1_read(s1_rd), .s1_write(s1_wr),
        .s1_byteenable(s1_be), .s1_writedata(s1_d), .s1_readdata(rdd[0]),
        .s1_readdatavalid(rdv[0]), .s1_waitrequest(wrq[0]),
        .s2_address(s2_a), .s2_chipselect(s2_cs), .s2_read(s2_rd), .s2_write(s2_wr),
        .s2_byteenable(s2_be), .s2_writedata(s2_d), .s2_readdata(rdd[1]),
        .s2_readdatavalid(rdv[1]), .s2_waitrequest(wrq[1]),
        .init_done(idone[0]), .collision_cnt(ccnt[0]), .fsm_state(fsm[0])
    );

    cpu_onchip_memory_dp #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_l2 (
        .clk(clk), .reset_n(reset_n), .reset_req(reset_req), .clken(clken),
        .s1_address(s1_a), .s1_chipselect(s1_cs), .s1_read(s1_rd), .s1_write(s1_wr),
        .s1_byteenable(s1_be), .s1_writedata(s1_d), .s1_readdata(rdd[2]),
        .s1_readdatavalid(rdv[2]), .s1_waitrequest(wrq[2]),
        .s2_address(s2_a), .s2_chipselect(s2_cs), .s2_read(s2_rd), .s2_write(s2_wr),
        .s2_byteenable(s2_be), .s2_writedata(s2_d), .s2_readdata(rdd[3]),
        .s2_readdatavalid(rdv[3]), .s2_waitrequest(wrq[3]),
        .init_done(idone[1]), .collision_cnt(ccnt[1]), .fsm_state(fsm[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt  = 0;

    logic [31:0] exp_q[$];
    int          sid_q[$];
    int          tag_q[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: counts enabled cycles and matches every readdatavalid pulse.
    always @(negedge clk) begin
        int idx;
        if (clken && !reset_req) en_cnt++;
        for (int k = 0; k < 4; k++) begin
            if (rdv[k]) begin
                idx = -1;
                for (int i = 0; i < sid_q.size(); i++) begin
                    if (sid_q[i] == k) begin
                        idx = i;
                        break;
                    end
                end
                if (idx < 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid stream %0d: got data %0h, expected no pulse", k, rdd[k]);
                end else begin
                    check($sformatf("rdata_stream%0d", k), rdd[k], exp_q[idx]);
                    check($sformatf("latency_stream%0d", k), en_cnt, tag_q[idx]);
                    exp_q.delete(idx);
                    sid_q.delete(idx);
                    tag_q.delete(idx);
                end
            end
        end
    end

    typedef struct {
        logic [2:0]  op1;   // {cs, rd, wr}
        logic [3:0]  be1;
        logic [3:0]  a1;
        logic [31:0] d1;
        logic [31:0] e1;
        logic [2:0]  op2;
        logic [3:0]  be2;
        logic [3:0]  a2;
        logic [31:0] d2;
        logic [31:0] e2;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    function automatic vec_t mk(logic [2:0] op1, logic [3:0] be1, logic [3:0] a1, logic [31:0] d1,
                                logic [31:0] e1, logic [2:0] op2, logic [3:0] be2, logic [3:0] a2,
                                logic [31:0] d2, logic [31:0] e2, logic [15:0] cnt);
        vec_t v;
        v.op1 = op1; v.be1 = be1; v.a1 = a1; v.d1 = d1; v.e1 = e1;
        v.op2 = op2; v.be2 = be2; v.a2 = a2; v.d2 = d2; v.e2 = e2;
        v.cnt = cnt;
        return v;
    endfunction

    task automatic drive_idle();
        s1_cs = 0; s1_rd = 0; s1_wr = 0; s1_be = 0; s1_a = 0; s1_d = 0;
        s2_cs = 0; s2_rd = 0; s2_wr = 0; s2_be = 0; s2_a = 0; s2_d = 0;
    endtask

    // Called just before the edge: pushes the expected data for each accepted read.
    task automatic push_reads(input logic [31:0] e1, input logic [31:0] e2);
        logic cs, rd, wr;
        for (int k = 0; k < 4; k++) begin
            cs = (k % 2) ? s2_cs : s1_cs;
            rd = (k % 2) ? s2_rd : s1_rd;
            wr = (k % 2) ? s2_wr : s1_wr;
            if (cs && rd && !wr && !wrq[k]) begin
                exp_q.push_back((k % 2) ? e2 : e1);
                sid_q.push_back(k);
                tag_q.push_back(en_cnt + 1 + ((k < 2) ? 1 : 2));
            end
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        {s1_cs, s1_rd, s1_wr} = v.op1; s1_be = v.be1; s1_a = v.a1; s1_d = v.d1;
        {s2_cs, s2_rd, s2_wr} = v.op2; s2_be = v.be2; s2_a = v.a2; s2_d = v.d2;
        #1;
        push_reads(v.e1, v.e2);
        @(posedge clk); #2;
        drive_idle();
        check({name, "_cnt_l1"}, ccnt[0], v.cnt);
        check({name, "_cnt_l2"}, ccnt[1], v.cnt);
    endtask

    // Holds an s2 read until accepted (bounded).
    task automatic rd_hold(input logic [3:0] a, input logic [31:0] e);
        int n = 0;
        s2_cs = 1; s2_rd = 1; s2_wr = 0; s2_a = a;
        forever begin
            #1;
            push_reads('0, e);
            if (!wrq[1] || n == 20) break;
            n++;
            @(posedge clk); #2;
        end
        check("rd_hold_accept", (n < 20), 1'b1);
        @(posedge clk); #2;
        drive_idle();
    endtask

    task automatic wait_clear(input string name);
        int n = 0;
        forever begin
            #1;
            if (!wrq[0] || n == 40) break;
            if (idone !== 2'b00) begin
                n_tests++; n_fail++;
                $display("FAIL %s_early_init_done: got %0b, expected 00", name, idone);
            end
            n++;
            @(posedge clk); #2;
        end
        check({name, "_cycles"}, n, 16);
        check({name, "_init_done"}, idone, 2'b11);
        check({name, "_waitreq_run"}, wrq, 4'b0000);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_waitreq"}, wrq, 4'b1111);
        check({name, "_rdv"}, rdv, 4'b0000);
        check({name, "_rdata"}, {rdd[0] | rdd[1] | rdd[2] | rdd[3]}, 32'h0);
        check({name, "_init_done"}, idone, 2'b00);
        check({name, "_cnt"}, {ccnt[0], ccnt[1]}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(3'b101, 4'hF, 4'd5,  32'h12345678, 32'h0,        3'b000, 4'h0, 4'd0,  32'h0,        32'h0,        16'd0);
        vecs[1]  = mk(3'b101, 4'h2, 4'd5,  32'hFFFFFFFF, 32'h0,        3'b000, 4'h0, 4'd0,  32'h0,        32'h0,        16'd0);
        vecs[2]  = mk(3'b000, 4'h0, 4'd0,  32'h0,        32'h0,        3'b110, 4'h0, 4'd5,  32'h0,        32'h1234FF78, 16'd0);
        vecs[3]  = mk(3'b101, 4'hF, 4'd3,  32'hAAAA0000, 32'h0,        3'b101, 4'hF, 4'd3,  32'h5555FFFF, 32'h0,        16'd1);
        vecs[4]  = mk(3'b110, 4'h0, 4'd3,  32'h0,        32'hAAAA0000, 3'b000, 4'h0, 4'd0,  32'h0,        32'h0,        16'd1);
        vecs[5]  = mk(3'b101, 4'hF, 4'd8,  32'h11111111, 32'h0,        3'b101, 4'hF, 4'd9,  32'h22222222, 32'h0,        16'd1);
        vecs[6]  = mk(3'b110, 4'h0, 4'd8,  32'h0,        32'h11111111, 3'b110, 4'h0, 4'd9,  32'h0,        32'h22222222, 16'd1);
        vecs[7]  = mk(3'b101, 4'hF, 4'd7,  32'hDEADBEEF, 32'h0,        3'b110, 4'h0, 4'd7,  32'h0,        32'h0,        16'd1);
        vecs[8]  = mk(3'b000, 4'h0, 4'd0,  32'h0,        32'h0,        3'b110, 4'h0, 4'd7,  32'h0,        32'hDEADBEEF, 16'd1);
        vecs[9]  = mk(3'b111, 4'hF, 4'd10, 32'h0BADF00D, 32'h0,        3'b000, 4'h0, 4'd0,  32'h0,        32'h0,        16'd1);
        vecs[10] = mk(3'b000, 4'h0, 4'd0,  32'h0,        32'h0,        3'b110, 4'h0, 4'd10, 32'h0,        32'h0BADF00D, 16'd1);
        vecs[11] = mk(3'b110, 4'h0, 4'd5,  32'h0,        32'h1234FF78, 3'b101, 4'h8, 4'd5,  32'h99000000, 32'h0,        16'd1);
        vecs[12] = mk(3'b110, 4'h0, 4'd5,  32'h0,        32'h9934FF78, 3'b000, 4'h0, 4'd0,  32'h0,        32'h0,        16'd1);

        reset_n = 0; reset_req = 0; clken = 1;
        drive_idle();
        repeat (2) @(posedge clk);
        #2;
        check_reset_vals("por");
        reset_n = 1;
        wait_clear("clear1");

        for (int a = 0; a < 16; a++) begin
            vec_t v;
            v = mk(3'b110, 4'h0, 4'(a), 32'h0, 32'h0, 3'b110, 4'h0, 4'(15 - a), 32'h0, 32'h0, 16'd0);
            apply(v, "zero_read");
        end

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // back-to-back reads with a 3-cycle clken stall in the middle
        rd_hold(4'd5, 32'h9934FF78);
        rd_hold(4'd3, 32'hAAAA0000);
        s2_cs = 1; s2_rd = 1; s2_a = 4'd8;
        clken = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_waitreq", wrq, 4'b1111);
            @(posedge clk); #2;
        end
        clken = 1;
        rd_hold(4'd8, 32'h11111111);
        rd_hold(4'd9, 32'h22222222);
        repeat (4) @(posedge clk);
        #2;
        check("stream_drained", exp_q.size(), 0);

        // reset while a read is in flight: its pulse must never appear
        s1_cs = 1; s1_rd = 1; s1_a = 4'd5;
        @(posedge clk); #2;
        drive_idle();
        reset_n = 0;
        #1;
        check_reset_vals("midread");
        @(posedge clk); #2;
        reset_n = 1;

        // reset again once clr_addr has reached 9
        repeat (9) @(posedge clk);
        #2;
        check("clear_pending", wrq, 4'b1111);
        reset_n = 0;
        #1;
        check_reset_vals("midclear");
        @(posedge clk); #2;
        reset_n = 1;
        wait_clear("clear2");

        apply(mk(3'b110, 4'h0, 4'd5, 32'h0, 32'h0, 3'b110, 4'h0, 4'd7, 32'h0, 32'h0, 16'd0), "post_clear");
        repeat (4) @(posedge clk);
        #2;
        check("final_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
